// File: rtl/seq_pattern_det_if.sv
// Bundle of the serial-detector signals: line-side inputs from the master,
// match flag / pulse / counter back from the detector (slave).
//
// Handshake: a bit on 'in' is consumed on every rising clk edge where
// in_valid is 1; there is no backpressure, so the detector is always ready.
// overlap and clr_count are sampled on every edge.
interface seq_pattern_det_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in;
    logic             overlap;
    logic             clr_count;
    logic             out;
    logic             match_pulse;
    logic [CNT_W-1:0] match_count;

    modport master (
        output in_valid, in, overlap, clr_count,
        input  out, match_pulse, match_count
    );

    modport slave (
        input  in_valid, in, overlap, clr_count,
        output out, match_pulse, match_count
    );
endinterface

// File: rtl/seq_pattern_det.sv
// Parametrised serial pattern detector (Moore). State s = number of leading
// PATTERN bits currently matched (0..LEN). The transition table is the
// KMP automaton of PATTERN, built entirely at elaboration time.
// With the default 3'b101 pattern, states 0/1/2/3 are the legacy A/B/C/D.
module seq_pattern_det #(
    parameter int             LEN     = 3,
    parameter logic [LEN-1:0] PATTERN = 3'b101,
    parameter int             CNT_W   = 8,
    localparam int            SW      = $clog2(LEN + 1)
) (
    input  logic                clk,
    input  logic                reset,
    seq_pattern_det_if.slave    bus,
    output logic [SW-1:0]       dbg_state_o
);

    if (LEN < 1 || LEN > 32) begin : g_bad_len
        $fatal(1, "seq_pattern_det: LEN must be in 1..32");
    end

    localparam logic [SW-1:0]    LEN_S   = SW'(LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Longest prefix of PATTERN that is a suffix of (first s pattern bits, b).
    // Pattern bit i (i = 0 is sent first) lives at PATTERN[LEN-1-i].
    function automatic int kmp_next(input int s, input logic b);
        int   n;
        int   k_max;
        int   m;
        int   res;
        logic ok;
        logic done;
        logic sb;
        n     = s + 1;
        k_max = (n > LEN) ? LEN : n;
        res   = 0;
        done  = 1'b0;
        for (int k = k_max; k >= 1; k--) begin
            if (!done) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++) begin
                    m  = n - k + j;
                    sb = (m < s) ? PATTERN[LEN-1-m] : b;
                    if (PATTERN[LEN-1-j] != sb) ok = 1'b0;
                end
                if (ok) begin
                    res  = k;
                    done = 1'b1;
                end
            end
        end
        return res;
    endfunction

    // Longest proper prefix of PATTERN that is also a suffix of it.
    function automatic int fail_len();
        int   res;
        logic ok;
        res = 0;
        for (int k = 1; k < LEN; k++) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
                if (PATTERN[LEN-1-j] != PATTERN[k-1-j]) ok = 1'b0;
            end
            if (ok) res = k;
        end
        return res;
    endfunction

    localparam int FAIL = fail_len();

    // Row LEN holds the overlapping continuation (restart from FAIL);
    // non-overlap mode reuses row 0 instead.
    logic [SW-1:0] nxt_tab [0:LEN][0:1];

    for (genvar gs = 0; gs <= LEN; gs++) begin : g_row
        for (genvar gb = 0; gb < 2; gb++) begin : g_col
            localparam int SRC = (gs == LEN) ? FAIL : gs;
            localparam int NXT = kmp_next(SRC, 1'(gb));
            assign nxt_tab[gs][gb] = SW'(NXT);
        end
    end

    logic [SW-1:0]    state_q;
    logic [SW-1:0]    state_d;
    logic [SW-1:0]    row_sel;
    logic             pulse_q;
    logic             hit;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next state from the table; a full match in non-overlap mode restarts at 0.
    always_comb begin
        row_sel = state_q;
        if (state_q == LEN_S && !bus.overlap) row_sel = '0;
        state_d = nxt_tab[row_sel][bus.in];
        hit     = bus.in_valid && (state_d == LEN_S);
    end

    // Saturating match counter; clear wins over a coincident increment.
    always_comb begin
        count_d = count_q;
        if (bus.clr_count) begin
            count_d = '0;
        end else if (hit && count_q != CNT_MAX) begin
            count_d = count_q + 1'b1;
        end
    end

    // State, pulse and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= '0;
            pulse_q <= 1'b0;
            count_q <= '0;
        end else begin
            if (bus.in_valid) state_q <= state_d;
            pulse_q <= hit;
            count_q <= count_d;
        end
    end

    assign bus.out         = (state_q == LEN_S);
    assign bus.match_pulse = pulse_q;
    assign bus.match_count = count_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_seq_pattern_det.sv
// Bench for seq_pattern_det. Four instances:
//   d0: defaults (101, CNT_W 8)   d1: 1101, LEN 4
//   d2: 101, CNT_W 2              d3: 111
// Expected match events go into exp_q as {dut id, count}; the monitor pops
// one entry per cycle in which a DUT shows match_pulse.
module tb_seq_pattern_det;

    logic clk;
    logic rst [4];
    logic v   [4];
    logic d   [4];
    logic ov  [4];
    logic cl  [4];
    logic mon_en [4];

    logic       p [4];
    logic       o [4];
    logic [7:0] c [4];
    logic [1:0] st0;
    logic [2:0] st1;
    logic [1:0] st2;
    logic [1:0] st3;

    logic [9:0] exp_q [$];
    int n_cmp;
    int n_fail;

    seq_pattern_det_if #(.CNT_W(8)) if0 ();
    seq_pattern_det_if #(.CNT_W(8)) if1 ();
    seq_pattern_det_if #(.CNT_W(2)) if2 ();
    seq_pattern_det_if #(.CNT_W(8)) if3 ();

    seq_pattern_det u_d0 (.clk(clk), .reset(rst[0]), .bus(if0), .dbg_state_o(st0));
    seq_pattern_det #(.LEN(4), .PATTERN(4'b1101), .CNT_W(8))
        u_d1 (.clk(clk), .reset(rst[1]), .bus(if1), .dbg_state_o(st1));
    seq_pattern_det #(.LEN(3), .PATTERN(3'b101), .CNT_W(2))
        u_d2 (.clk(clk), .reset(rst[2]), .bus(if2), .dbg_state_o(st2));
    seq_pattern_det #(.LEN(3), .PATTERN(3'b111), .CNT_W(8))
        u_d3 (.clk(clk), .reset(rst[3]), .bus(if3), .dbg_state_o(st3));

    assign if0.in_valid = v[0];  assign if0.in = d[0];
    assign if0.overlap  = ov[0]; assign if0.clr_count = cl[0];
    assign if1.in_valid = v[1];  assign if1.in = d[1];
    assign if1.overlap  = ov[1]; assign if1.clr_count = cl[1];
    assign if2.in_valid = v[2];  assign if2.in = d[2];
    assign if2.overlap  = ov[2]; assign if2.clr_count = cl[2];
    assign if3.in_valid = v[3];  assign if3.in = d[3];
    assign if3.overlap  = ov[3]; assign if3.clr_count = cl[3];

    assign p[0] = if0.match_pulse; assign o[0] = if0.out; assign c[0] = if0.match_count;
    assign p[1] = if1.match_pulse; assign o[1] = if1.out; assign c[1] = if1.match_count;
    assign p[2] = if2.match_pulse; assign o[2] = if2.out; assign c[2] = {6'b0, if2.match_count};
    assign p[3] = if3.match_pulse; assign o[3] = if3.out; assign c[3] = if3.match_count;

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input int id, input int unsigned act,
                         input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d expected %0d", nm, id, act, exp);
        end
    endtask

    // Monitor: every match pulse must correspond to the next expected event.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (p[i] === 1'b1 && mon_en[i]) begin
                if (exp_q.size() == 0) begin
                    check("pulse_unexpected", i, 1, 0);
                end else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    check("pulse_dut_id", i, i, 32'(e[9:8]));
                    check("pulse_count", i, 32'(c[i]), 32'(e[7:0]));
                    check("pulse_out", i, 32'(o[i]), 1);
                end
            end
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bit_in(input int id, input logic b);
        v[id] = 1'b1;
        d[id] = b;
        step();
        v[id] = 1'b0;
    endtask

    task automatic bubble(input int id, input int n);
        v[id] = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_reset(input int id);
        rst[id] = 1'b1;
        v[id]   = 1'b0;
        step();
        rst[id] = 1'b0;
    endtask

    task automatic expect_match(input int id, input int cnt);
        exp_q.push_back({2'(id), 8'(cnt)});
    endtask

    initial begin
        int ls;
        logic b;
        n_cmp  = 0;
        n_fail = 0;
        for (int i = 0; i < 4; i++) begin
            rst[i] = 1'b1; v[i] = 1'b0; d[i] = 1'b0;
            ov[i] = 1'b1; cl[i] = 1'b0; mon_en[i] = 1'b1;
        end
        mon_en[0] = 1'b0;
        step();
        step();
        for (int i = 0; i < 4; i++) rst[i] = 1'b0;

        // Reset state
        for (int i = 0; i < 4; i++) begin
            check("rst_out", i, 32'(o[i]), 0);
            check("rst_pulse", i, 32'(p[i]), 0);
            check("rst_count", i, 32'(c[i]), 0);
        end
        check("rst_state", 1, 32'(st1), 0);

        // Legacy A/B/C/D equivalence, random stream
        ls = 0;
        for (int k = 0; k < 10000; k++) begin
            b = 1'($urandom_range(0, 1));
            bit_in(0, b);
            case (ls)
                0: ls = b ? 1 : 0;
                1: ls = b ? 1 : 2;
                2: ls = b ? 3 : 0;
                default: ls = b ? 1 : 2;
            endcase
            check("legacy_out", 0, 32'(o[0]), (ls == 3) ? 1 : 0);
            check("legacy_state", 0, 32'(st0), 32'(ls));
        end
        do_reset(0);
        mon_en[0] = 1'b1;

        // Overlap mode on 1,0,1,0,1
        ov[0] = 1'b1;
        expect_match(0, 1);
        expect_match(0, 2);
        bit_in(0, 1); bit_in(0, 0); bit_in(0, 1); bit_in(0, 0); bit_in(0, 1);
        check("ovl_count", 0, 32'(c[0]), 2);
        check("ovl_out", 0, 32'(o[0]), 1);
        bubble(0, 1);

        // Non-overlap mode on the same stream
        do_reset(0);
        ov[0] = 1'b0;
        expect_match(0, 1);
        bit_in(0, 1); bit_in(0, 0); bit_in(0, 1); bit_in(0, 0); bit_in(0, 1);
        check("novl_count", 0, 32'(c[0]), 1);
        check("novl_out", 0, 32'(o[0]), 0);
        bubble(0, 1);

        // Valid gating on 1101 with bubbles
        do_reset(1);
        expect_match(1, 1);
        bit_in(1, 1); bubble(1, 1);
        bit_in(1, 1); bubble(1, 2);
        bit_in(1, 0); bubble(1, 1);
        check("gate_out_pre", 1, 32'(o[1]), 0);
        bit_in(1, 1);
        check("gate_out", 1, 32'(o[1]), 1);
        check("gate_pulse", 1, 32'(p[1]), 1);
        for (int k = 0; k < 3; k++) begin
            bubble(1, 1);
            check("gate_hold_out", 1, 32'(o[1]), 1);
            check("gate_hold_pulse", 1, 32'(p[1]), 0);
        end
        check("gate_count", 1, 32'(c[1]), 1);

        // Reset mid-pattern discards the partial match
        do_reset(1);
        bit_in(1, 1); bit_in(1, 1); bit_in(1, 0);
        do_reset(1);
        check("midrst_count", 1, 32'(c[1]), 0);
        bit_in(1, 1);
        check("midrst_out", 1, 32'(o[1]), 0);
        check("midrst_state", 1, 32'(st1), 1);
        bubble(1, 2);
        expect_match(1, 1);
        bit_in(1, 1); bit_in(1, 1); bit_in(1, 0); bit_in(1, 1);
        check("midrst_match_out", 1, 32'(o[1]), 1);
        check("midrst_match_cnt", 1, 32'(c[1]), 1);
        bubble(1, 1);

        // Saturation with a 2-bit counter: five matches
        do_reset(2);
        expect_match(2, 1); expect_match(2, 2); expect_match(2, 3);
        expect_match(2, 3); expect_match(2, 3);
        bit_in(2, 1);
        for (int k = 0; k < 5; k++) begin
            bit_in(2, 0);
            bit_in(2, 1);
        end
        check("sat_count", 2, 32'(c[2]), 3);
        // Clear coincident with a match: 0 then 1 re-completes 101
        expect_match(2, 0);
        bit_in(2, 0);
        cl[2] = 1'b1;
        bit_in(2, 1);
        cl[2] = 1'b0;
        check("clr_count", 2, 32'(c[2]), 0);
        check("clr_pulse", 2, 32'(p[2]), 1);
        check("clr_out", 2, 32'(o[2]), 1);
        bubble(2, 1);

        // All-ones pattern, overlap: four back-to-back pulses
        do_reset(3);
        ov[3] = 1'b1;
        for (int k = 1; k <= 4; k++) expect_match(3, k);
        for (int k = 0; k < 6; k++) begin
            bit_in(3, 1);
            if (k >= 2) check("ones_pulse", 3, 32'(p[3]), 1);
        end
        check("ones_ovl_count", 3, 32'(c[3]), 4);
        bubble(3, 1);
        check("ones_pulse_end", 3, 32'(p[3]), 0);

        // All-ones pattern, non-overlap: two matches
        do_reset(3);
        ov[3] = 1'b0;
        expect_match(3, 1);
        expect_match(3, 2);
        for (int k = 0; k < 6; k++) bit_in(3, 1);
        check("ones_novl_count", 3, 32'(c[3]), 2);
        bubble(3, 2);

        // Every expected match event must have been observed
        check("queue_drain", 0, 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
